store_align_unit: RTL and testbench
===================================

# store_align_unit

- Store-side counterpart of the load-extension path: formats a store before it reaches the word-organised Data Memory.
- Takes a byte address, rs2 value and store type (SB/SH/SW); produces word-address, byte-enable and byte-lane-aligned write-data beats.
- Sits between the MEM-stage store request and the Data Memory write port, using a valid/ready handshake on both sides.
- A store that crosses a word boundary is split into two sequential memory beats.

## Interface

Parameters:
- none (all widths fixed: 32-bit data, 32-bit byte address, 30-bit word address)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- CPU_RST_N  in  1  reset; synchronous, active-low
- ReqValid  in  1  store request present
- ReqReady  out  1  unit can accept a request
- ReqAddr  in  32  byte address of the store
- ReqData  in  32  register value to store; the low byte or halfword is used for SB/SH
- ReqType  in  2  store type:
  - 00: none
  - 01: SB
  - 10: SH
  - 11: SW
- MemValid  out  1  memory beat present
- MemReady  in  1  memory accepts beat
- MemWordAddr  out  30  word address of beat
- MemWData  out  32  lane-aligned write data; disabled lanes are 0
- MemByteEn  out  4  byte enables; bit i covers MemWData[8i+7:8i]
- Busy  out  1  high whenever state is not IDLE
- MisalignErr  out  1  one-cycle pulse: boundary-crossing store dropped (macro off only)

## Operation

- FSM states: IDLE, BEAT0, BEAT1.
- ReqReady = (state == IDLE). A request is accepted on a cycle where ReqValid && ReqReady.
- On acceptance, let o = ReqAddr[1:0] and compute:
  - base mask: SB = 0001, SH = 0011, SW = 1111
  - base data: SB = {24'b0, ReqData[7:0]}, SH = {16'b0, ReqData[15:0]}, SW = ReqData
  - mask8 = {4'b0, base} << o
  - wide64 = {32'b0, base data} << (8*o)
- Beat 0 is registered as:
  - word address ReqAddr[31:2]
  - data wide64[31:0]
  - enables mask8[3:0]
- If mask8[7:4] != 0, beat 1 is also registered:
  - word address ReqAddr[31:2] + 1, mod 2^30 (0x3FFFFFFF wraps to 0)
  - data wide64[63:32]
  - enables mask8[7:4]
- Transitions:
  - IDLE -> BEAT0 on acceptance of a type 01/10/11 request with no error.
  - ReqType 00 is accepted and consumed: no beat, stays IDLE.
  - BEAT0 with MemReady: -> BEAT1 if a split is pending, else -> IDLE.
  - BEAT1 with MemReady: -> IDLE.
  - BEAT0/BEAT1 without MemReady: hold state.
- MemValid = 1 exactly in BEAT0/BEAT1. MemWordAddr, MemWData and MemByteEn are held stable while MemValid && !MemReady.
- MemValid never depends combinationally on MemReady.

## Timing

- Reset (CPU_RST_N low at a rising edge):
  - state = IDLE, MemValid = 0, MemWordAddr = 0, MemWData = 0, MemByteEn = 0, Busy = 0, MisalignErr = 0
  - ReqReady = 1 from the first cycle after reset.
- Reset mid-operation: any pending beat, including beat 1 of a split, is dropped. No partial retry.
- Latency: a request accepted at edge N presents beat 0 from cycle N+1.
- Beat 1 is presented on the cycle after beat 0 handshakes.
- Throughput with MemReady tied high:
  - aligned store: 1 per 2 cycles
  - split store: 1 per 3 cycles
- MisalignErr asserts in cycle N+1 for exactly one cycle. State remains IDLE.
- Outputs are registered; ReqReady is decoded from state only.

## Configuration

- MISALIGNED_STORE_EN defined: boundary-crossing SH/SW is split into two beats as above. MisalignErr is tied to 0.
- MISALIGNED_STORE_EN undefined: a boundary-crossing store is accepted and not written (MemValid stays 0). MisalignErr pulses once.
  - Boundary-crossing cases: SH with o = 3; SW with o != 0.
- Aligned and in-word stores behave identically in both builds.

## Test plan

- SW, ReqAddr 0x00000100, ReqData 0xDEADBEEF, MemReady = 1 -> one beat at N+1: word 0x40, BE 1111, data 0xDEADBEEF. ReqReady back to 1 at N+2.
- SB, ReqAddr 0x00000103, ReqData 0x123456AB -> word 0x40, BE 1000, data 0xAB000000.
- SH, ReqAddr 0x00000203, ReqData 0x0000CAFE:
  - macro on -> beat 0: word 0x80, BE 1000, data 0xFE000000; then beat 1: word 0x81, BE 0001, data 0x000000CA.
  - macro off -> no MemValid; MisalignErr high for one cycle at N+1.
- SW, ReqAddr 0x00000004, MemReady low for 3 cycles -> MemValid and all beat fields stable for 4 cycles; ReqReady = 0 and Busy = 1 throughout; beat completes on the 4th cycle.
- SW, ReqAddr 0xFFFFFFFE, ReqData 0x11223344, macro on -> beat 0: word 0x3FFFFFFF, BE 1100, data 0x33440000; beat 1: word 0x00000000, BE 0011, data 0x00001122.
- CPU_RST_N low during BEAT1 of a split -> next cycle MemValid 0, MemByteEn 0, ReqReady 1. A following SW to 0x00000008 completes normally.

Source files
------------

// File: rtl/store_align_unit.sv
// store_align_unit: formats SB/SH/SW stores into word-organised memory beats.
// A store is turned into a word address, lane-aligned write data and byte
// enables. Stores that cross a word boundary are handled according to the
// MISALIGNED_STORE_EN macro:
//   defined   -> split into two sequential beats (MisalignErr tied to 0)
//   undefined -> dropped, with a one-cycle MisalignErr pulse
module store_align_unit (
  input  logic        CLK,
  input  logic        CPU_RST_N,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqData,
  input  logic [1:0]  ReqType,
  output logic        MemValid,
  input  logic        MemReady,
  output logic [29:0] MemWordAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemByteEn,
  output logic        Busy,
  output logic        MisalignErr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t      state_reg, state_next;

  logic [29:0] word_addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  byte_en_reg;
  logic [29:0] hi_addr_reg;
  logic [31:0] hi_data_reg;
  logic [3:0]  hi_en_reg;
  logic        split_reg;
  logic        misalign_reg;
  logic        misalign_next;

  logic [3:0]  base_mask;
  logic [31:0] base_data;
  logic [7:0]  mask8;
  logic [63:0] wide64;
  logic        crosses;
  logic        req_split;
  logic        req_err;

  // Lane alignment of the incoming request: shift mask and data by the byte offset
  always_comb begin
    base_mask = 4'b0000;
    base_data = 32'h0;
    case (ReqType)
      2'b01: begin
        base_mask = 4'b0001;
        base_data = {24'h0, ReqData[7:0]};
      end
      2'b10: begin
        base_mask = 4'b0011;
        base_data = {16'h0, ReqData[15:0]};
      end
      2'b11: begin
        base_mask = 4'b1111;
        base_data = ReqData;
      end
      default: begin
        base_mask = 4'b0000;
        base_data = 32'h0;
      end
    endcase
    mask8   = {4'b0000, base_mask} << ReqAddr[1:0];
    wide64  = {32'h0, base_data} << {ReqAddr[1:0], 3'b000};
    crosses = |mask8[7:4];
`ifdef MISALIGNED_STORE_EN
    req_split = crosses;
    req_err   = 1'b0;
`else
    req_split = 1'b0;
    req_err   = crosses;
`endif
  end

  // State register; reset drops any pending beat including a split's second half
  always_ff @(posedge CLK) begin
    if (!CPU_RST_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and the one-cycle misalignment flag
  always_comb begin
    state_next    = state_reg;
    misalign_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ReqValid && ReqType != 2'b00) begin
          if (req_err) begin
            misalign_next = 1'b1;
          end else begin
            state_next = BEAT0;
          end
        end
      end
      BEAT0: begin
        if (MemReady) begin
          state_next = split_reg ? BEAT1 : IDLE;
        end
      end
      BEAT1: begin
        if (MemReady) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat registers: load beat 0 on acceptance, swap in beat 1 after beat 0 handshakes
  always_ff @(posedge CLK) begin
    if (!CPU_RST_N) begin
      word_addr_reg <= 30'h0;
      wdata_reg     <= 32'h0;
      byte_en_reg   <= 4'h0;
      hi_addr_reg   <= 30'h0;
      hi_data_reg   <= 32'h0;
      hi_en_reg     <= 4'h0;
      split_reg     <= 1'b0;
      misalign_reg  <= 1'b0;
    end else begin
      misalign_reg <= misalign_next;
      if (state_reg == IDLE && state_next == BEAT0) begin
        word_addr_reg <= ReqAddr[31:2];
        wdata_reg     <= wide64[31:0];
        byte_en_reg   <= mask8[3:0];
        hi_addr_reg   <= ReqAddr[31:2] + 30'd1;
        hi_data_reg   <= wide64[63:32];
        hi_en_reg     <= mask8[7:4];
        split_reg     <= req_split;
      end else if (state_reg == BEAT0 && MemReady && split_reg) begin
        word_addr_reg <= hi_addr_reg;
        wdata_reg     <= hi_data_reg;
        byte_en_reg   <= hi_en_reg;
        split_reg     <= 1'b0;
      end
    end
  end

  assign ReqReady    = (state_reg == IDLE);
  assign Busy        = (state_reg != IDLE);
  assign MemValid    = (state_reg == BEAT0) || (state_reg == BEAT1);
  assign MemWordAddr = word_addr_reg;
  assign MemWData    = wdata_reg;
  assign MemByteEn   = byte_en_reg;
  assign MisalignErr = misalign_reg;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed testbench for store_align_unit; expectations follow the
// MISALIGNED_STORE_EN build the bench is compiled with.
module tb_store_align_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_type;
  logic        mem_valid;
  logic        mem_ready;
  logic [29:0] mem_word_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        busy;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  store_align_unit dut (
    .CLK         (clk),
    .CPU_RST_N   (rst_n),
    .ReqValid    (req_valid),
    .ReqReady    (req_ready),
    .ReqAddr     (req_addr),
    .ReqData     (req_data),
    .ReqType     (req_type),
    .MemValid    (mem_valid),
    .MemReady    (mem_ready),
    .MemWordAddr (mem_word_addr),
    .MemWData    (mem_wdata),
    .MemByteEn   (mem_byte_en),
    .Busy        (busy),
    .MisalignErr (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [29:0] waddr,
                            input logic [3:0] be, input logic [31:0] data);
    check({tag, ".valid"}, {31'h0, mem_valid}, 32'h1);
    check({tag, ".addr"}, {2'b00, mem_word_addr}, {2'b00, waddr});
    check({tag, ".be"}, {28'h0, mem_byte_en}, {28'h0, be});
    check({tag, ".data"}, mem_wdata, data);
    $display("beat %s: word=%h be=%b data=%h", tag, mem_word_addr, mem_byte_en, mem_wdata);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, {31'h0, mem_valid}, 32'h0);
    check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
    check({tag, ".busy"}, {31'h0, busy}, 32'h0);
  endtask

  // Present a request for exactly one edge, then withdraw it
  task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_data  = d;
    step();
    req_valid = 1'b0;
    $display("req type=%b addr=%h data=%h", t, a, d);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    req_type  = 2'b00;
    mem_ready = 1'b1;
    step();
    step();
    check("rst.valid", {31'h0, mem_valid}, 32'h0);
    check("rst.ready", {31'h0, req_ready}, 32'h1);
    check("rst.busy", {31'h0, busy}, 32'h0);
    check("rst.addr", {2'b00, mem_word_addr}, 32'h0);
    check("rst.data", mem_wdata, 32'h0);
    check("rst.be", {28'h0, mem_byte_en}, 32'h0);
    check("rst.err", {31'h0, misalign_err}, 32'h0);
    rst_n = 1'b1;
    step();

    // Aligned SW
    issue(2'b11, 32'h0000_0100, 32'hDEAD_BEEF);
    check_beat("sw100", 30'h40, 4'b1111, 32'hDEAD_BEEF);
    check("sw100.ready", {31'h0, req_ready}, 32'h0);
    check("sw100.busy", {31'h0, busy}, 32'h1);
    step();
    check_idle("sw100.done");

    // SB to the top lane
    issue(2'b01, 32'h0000_0103, 32'h1234_56AB);
    check_beat("sb103", 30'h40, 4'b1000, 32'hAB00_0000);
    step();
    check_idle("sb103.done");

    // In-word SH at offsets 2 and 1
    issue(2'b10, 32'h0000_0202, 32'h0000_CAFE);
    check_beat("sh202", 30'h80, 4'b1100, 32'hCAFE_0000);
    step();
    check_idle("sh202.done");
    issue(2'b10, 32'h0000_0201, 32'h5555_CAFE);
    check_beat("sh201", 30'h80, 4'b0110, 32'h00CA_FE00);
    step();
    check_idle("sh201.done");

    // Boundary-crossing SH
    issue(2'b10, 32'h0000_0203, 32'h0000_CAFE);
`ifdef MISALIGNED_STORE_EN
    check_beat("sh203.b0", 30'h80, 4'b1000, 32'hFE00_0000);
    check("sh203.err", {31'h0, misalign_err}, 32'h0);
    step();
    check_beat("sh203.b1", 30'h81, 4'b0001, 32'h0000_00CA);
    step();
    check_idle("sh203.done");
`else
    check("sh203.valid", {31'h0, mem_valid}, 32'h0);
    check("sh203.err", {31'h0, misalign_err}, 32'h1);
    check("sh203.ready", {31'h0, req_ready}, 32'h1);
    step();
    check("sh203.err_end", {31'h0, misalign_err}, 32'h0);
    check("sh203.valid2", {31'h0, mem_valid}, 32'h0);
`endif

    // Back-pressure: MemReady low for 3 cycles, beat completes on the 4th
    mem_ready = 1'b0;
    issue(2'b11, 32'h0000_0004, 32'hA5A5_5A5A);
    for (int i = 0; i < 4; i++) begin
      check_beat("bp", 30'h1, 4'b1111, 32'hA5A5_5A5A);
      check("bp.ready", {31'h0, req_ready}, 32'h0);
      check("bp.busy", {31'h0, busy}, 32'h1);
      if (i == 3) mem_ready = 1'b1;
      step();
    end
    check_idle("bp.done");

    // SW wrapping the top of the address space
    issue(2'b11, 32'hFFFF_FFFE, 32'h1122_3344);
`ifdef MISALIGNED_STORE_EN
    check_beat("wrap.b0", 30'h3FFF_FFFF, 4'b1100, 32'h3344_0000);
    step();
    check_beat("wrap.b1", 30'h0000_0000, 4'b0011, 32'h0000_1122);
    step();
    check_idle("wrap.done");
`else
    check("wrap.valid", {31'h0, mem_valid}, 32'h0);
    check("wrap.err", {31'h0, misalign_err}, 32'h1);
    step();
    check("wrap.err_end", {31'h0, misalign_err}, 32'h0);
`endif

    // Type 00 is consumed with no beat and no error
    issue(2'b00, 32'h0000_0013, 32'hFFFF_FFFF);
    check_idle("none");
    check("none.err", {31'h0, misalign_err}, 32'h0);

    // Reset in the middle of an operation
`ifdef MISALIGNED_STORE_EN
    issue(2'b10, 32'h0000_0203, 32'h0000_CAFE);
    step();
    check_beat("rstmid.b1", 30'h81, 4'b0001, 32'h0000_00CA);
`else
    mem_ready = 1'b0;
    issue(2'b11, 32'h0000_0010, 32'h0BAD_F00D);
    check_beat("rstmid.b0", 30'h4, 4'b1111, 32'h0BAD_F00D);
    mem_ready = 1'b1;
`endif
    rst_n = 1'b0;
    step();
    check("rstmid.valid", {31'h0, mem_valid}, 32'h0);
    check("rstmid.be", {28'h0, mem_byte_en}, 32'h0);
    check("rstmid.ready", {31'h0, req_ready}, 32'h1);
    rst_n = 1'b1;

    issue(2'b11, 32'h0000_0008, 32'hCAFE_BABE);
    check_beat("sw008", 30'h2, 4'b1111, 32'hCAFE_BABE);
    step();
    check_idle("sw008.done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
